// File: rtl/seq_generator_if.sv
// Bus bundle between the serial pattern generator and its consumer.
// With SEQGEN_REF_DETECT_EN defined the bundle also carries z_ref.
interface seq_generator_if #(
  parameter int N     = 8,
  parameter int RPT_W = 4
);
  logic             start;
  logic [N-1:0]     pattern;
  logic [RPT_W-1:0] repeat_cnt;
  logic             w;
  logic             w_valid;
  logic             busy;
  logic             done;
`ifdef SEQGEN_REF_DETECT_EN
  logic             z_ref;

  modport master (input start, pattern, repeat_cnt,
                  output w, w_valid, busy, done, z_ref);
  modport slave  (output start, pattern, repeat_cnt,
                  input w, w_valid, busy, done, z_ref);
`else
  modport master (input start, pattern, repeat_cnt,
                  output w, w_valid, busy, done);
  modport slave  (output start, pattern, repeat_cnt,
                  input w, w_valid, busy, done);
`endif
endinterface

// File: rtl/seq_generator.sv
// Serial MSB-first test-pattern transmitter with back-to-back repeats and a done pulse.
// SEQGEN_REF_DETECT_EN adds a registered golden 00/11 detector output (z_ref).
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// SHIFT | one pattern bit on w per clock, reloading from the hold copy on repeats
// DONE  | single-cycle done pulse, then back to IDLE
module seq_generator #(
  parameter int N     = 8,
  parameter int RPT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  seq_generator_if.master bus
);
  localparam int IW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_d;
  logic [N-1:0]     shreg, shreg_d;
  logic [N-1:0]     hold, hold_d;
  logic [IW-1:0]    idx, idx_d;
  logic [RPT_W-1:0] reps_left, reps_left_d;
  logic             w_q, w_d;
  logic             w_valid_q, w_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      hold      <= '0;
      idx       <= '0;
      reps_left <= '0;
      w_q       <= 1'b0;
      w_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      hold      <= hold_d;
      idx       <= idx_d;
      reps_left <= reps_left_d;
      w_q       <= w_d;
      w_valid_q <= w_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // shreg holds the bits still to be sent, left-aligned; w already carries the current one.
  always_comb begin
    state_d     = state;
    shreg_d     = shreg;
    hold_d      = hold;
    idx_d       = idx;
    reps_left_d = reps_left;
    w_d         = 1'b0;
    w_valid_d   = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_d     = SHIFT;
          hold_d      = bus.pattern;
          shreg_d     = {bus.pattern[N-2:0], 1'b0};
          idx_d       = IW'(N - 1);
          reps_left_d = bus.repeat_cnt;
          w_d         = bus.pattern[N-1];
          w_valid_d   = 1'b1;
          busy_d      = 1'b1;
        end
      end
      SHIFT: begin
        busy_d = 1'b1;
        if (idx != '0) begin
          idx_d     = idx - IW'(1);
          shreg_d   = {shreg[N-2:0], 1'b0};
          w_d       = shreg[N-1];
          w_valid_d = 1'b1;
        end else if (reps_left != '0) begin
          reps_left_d = reps_left - RPT_W'(1);
          idx_d       = IW'(N - 1);
          shreg_d     = {hold[N-2:0], 1'b0};
          w_d         = hold[N-1];
          w_valid_d   = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.w       = w_q;
  assign bus.w_valid = w_valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

`ifdef SEQGEN_REF_DETECT_EN
  logic prev_bit, prev_valid, z_ref_q;

  // History restarts whenever w_valid drops, so it never spans two transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_ref_q    <= 1'b0;
      prev_bit   <= 1'b0;
      prev_valid <= 1'b0;
    end else if (w_valid_q) begin
      z_ref_q    <= prev_valid && (w_q == prev_bit);
      prev_bit   <= w_q;
      prev_valid <= 1'b1;
    end else begin
      z_ref_q    <= 1'b0;
      prev_valid <= 1'b0;
    end
  end

  assign bus.z_ref = z_ref_q;
`endif
endmodule

// File: doc/seq_generator.md
Name: seq_generator

Overview:
- Serial test-pattern transmitter that drives the single-bit `w` stream consumed by the 00/11 sequence detector.
- Loads an N-bit pattern on a start request and shifts it out MSB-first, one bit per clock.
- Optionally repeats the pattern back-to-back, then pulses `done`.
- Used as stimulus source in labs and benches for the detector state machines.

Parameters:
- N, 8, pattern width in bits (N >= 2)
- RPT_W, 4, width of repeat-count input

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request to begin transmission; sampled only in IDLE
- pattern  input  N  bits to transmit, MSB sent first; captured on accepted start
- repeat_cnt  input  RPT_W  extra repetitions; total bits sent = N*(repeat_cnt+1)
- w  output  1  serial data bit, registered
- w_valid  output  1  high while `w` carries a pattern bit, registered
- busy  output  1  high in SHIFT and DONE states
- done  output  1  one-cycle pulse after the last bit
- z_ref  output  1  reference detector output (present only with SEQGEN_REF_DETECT_EN)

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- While rst is high: state=IDLE, and w, w_valid, busy, done, z_ref are all 0.
- Internal registers are cleared on reset: shift register, pattern copy, bit index, reps_left.
- States: IDLE, SHIFT, DONE (3-bit or 2-bit encoding); any illegal encoding goes to IDLE.
- IDLE:
  - w=0, w_valid=0, busy=0.
  - On posedge with start=1: capture pattern into the shift register and a hold copy, reps_left<=repeat_cnt, idx<=N-1, go to SHIFT.
  - Also at that edge: w<=pattern[N-1], w_valid<=1.
  - Latency: first bit appears in the cycle after start is sampled.
- SHIFT:
  - Each posedge advances one bit MSB-first; w_valid stays 1.
  - When the bit with idx=0 is on w and reps_left>0: reload from the hold copy, reps_left-1, idx<=N-1. There is no gap cycle; w_valid stays continuous.
  - When the bit with idx=0 is on w and reps_left==0: go to DONE, with w<=0, w_valid<=0, done<=1.
- DONE:
  - Lasts exactly one cycle with done=1 and busy=1, then goes to IDLE (done<=0, busy<=0).
  - start is ignored in DONE; a new transfer needs start sampled in IDLE.
- start, pattern and repeat_cnt changes while busy are ignored.
- repeat_cnt=0 sends one copy. repeat_cnt=2^RPT_W-1 sends 2^RPT_W copies; reps_left never wraps.
- Reset mid-transfer: all outputs drop immediately (asynchronously), no done pulse, and the transfer is lost.
- All outputs are driven from registers; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: SEQGEN_REF_DETECT_EN.
- Defined: adds the z_ref port and a golden model of the 00/11 detector, with registers prev_bit and prev_valid.
  - On each posedge with w_valid=1: z_ref<=prev_valid && (w==prev_bit), prev_bit<=w, prev_valid<=1.
  - On each posedge with w_valid=0: z_ref<=0, prev_valid<=0. History therefore never spans two transfers.
  - Reset clears z_ref, prev_bit and prev_valid.
- Undefined: the z_ref port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then start with pattern=8'b1011_0010, repeat_cnt=0:
  - w=1,0,1,1,0,0,1,0 in cycles 1..8 after start, with w_valid=1.
  - Cycle 9: done=1, w_valid=0. Cycle 10: busy=0.
- pattern=8'hA5, repeat_cnt=2: 24 contiguous valid bits forming A5,A5,A5 with no w_valid gap; a single done pulse at cycle 25.
- Hold start=1 for the whole transfer with pattern=8'hFF, repeat_cnt=0:
  - Exactly 8 bits are sent, then done.
  - A new transfer starts only from IDLE (first bit at cycle 11).
  - Changing pattern mid-transfer does not alter the bits sent.
- pattern=8'hF0, repeat_cnt=1, assert rst during the 4th bit:
  - w, w_valid, busy drop without waiting for a clock edge; no done pulse.
  - A later start with pattern=8'h81 sends 1,0,0,0,0,0,0,1.
- Macro on, pattern=8'b1100_0110, repeat_cnt=0:
  - Bits 1,1,0,0,0,1,1,0 are sent.
  - z_ref=1 exactly in cycles 3, 5, 6, 8; 0 otherwise.
  - A second transfer starts with z_ref=0 for its first two cycles.
- pattern=8'h01, repeat_cnt=1: 16 contiguous bits 00000001_00000001; w_valid stays high across the reload boundary.
